io_data_mem: RTL and testbench
==============================

IO_DATA_MEM -- requirements
Module: io_data_mem

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 64, giving the data RAM depth in 32-bit words; it is fixed at 64 for this address map.
REQ-002 The block SHALL have parameter SW_W, default 10, giving the switch input width.
REQ-003 The block SHALL have parameter KEY_W, default 4, giving the push-key input width.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port wmem, input, 1 bit, the store strobe from the CPU MEM stage.
REQ-007 The block SHALL have port addr, input, 32 bits, the byte address (CPU ALU result).
REQ-008 The block SHALL have port wdata, input, 32 bits, the store data.
REQ-009 The block SHALL have port rdata, output, 32 bits, the load data returned to the CPU.
REQ-010 The block SHALL have port sw, input, SW_W bits, asynchronous switch levels.
REQ-011 The block SHALL have port key, input, KEY_W bits, asynchronous key levels, active-high.
REQ-012 The block SHALL have port out0, output, 32 bits, general output register 0.
REQ-013 The block SHALL have port out1, output, 32 bits, general output register 1.

Function
REQ-014 The block SHALL ignore addr[1:0] and addr[31:8], decoding only addr[7:2].
REQ-015 The block SHALL map addr[7]=0 to RAM word addr[6:2] ... addr[7:2] within 0x00-0x7C (32 words accessible, upper RAM words reserved).
REQ-016 The block SHALL map I/O registers as: 0x80 SW (RO), 0x84 KEY (RO), 0x88 EDGE (R/W1C), 0x8C CNT (RO), 0x90 CTRL (RW), 0xC0 OUT0 (RW), 0xC4 OUT1 (RW).
REQ-017 The block SHALL drive rdata combinationally from addr in the same cycle, with no clock latency, so the CPU can capture and forward it within the MEM stage.
REQ-018 The block SHALL return zero on rdata for unmapped I/O addresses and SHALL ignore writes to them and to RO registers.
REQ-019 The block SHALL perform a RAM or register write on the rising edge at which wmem=1; the written value SHALL be visible on rdata from the following cycle.
REQ-020 The block SHALL pass sw and key through two-flop synchronizers; a stable input change SHALL appear on SW/KEY reads exactly two rising edges later.
REQ-021 The block SHALL set EDGE bit i on the edge after synchronized key[i] goes 0->1.
REQ-022 The block SHALL clear each EDGE bit written with 1 while wmem=1 at 0x88; on a simultaneous set and clear, set SHALL win.
REQ-023 The block SHALL increment the 32-bit CNT each cycle while CTRL[0]=1, wrapping 0xFFFFFFFF->0x00000000.
REQ-024 The block SHALL zero CNT on a CTRL write with wdata[1]=1; clear SHALL win over a same-cycle increment; CTRL[1] SHALL read back 0.
REQ-025 The block SHALL keep CTRL[31:1] reading as zero.
REQ-026 The block SHALL drive out0/out1 directly from the OUT0/OUT1 registers.
REQ-027 The block SHALL produce reads free of side effects, so repeated reads during CPU stalls are harmless.

Reset
REQ-028 The block SHALL, when resetn=0, asynchronously clear out0, out1, CTRL, CNT, EDGE and the synchronizer flops to zero.
REQ-029 The block SHALL leave RAM contents unaffected by reset.
REQ-030 The block SHALL ignore wmem while resetn=0 and resume normal operation on the first rising edge after deassertion.

Verification
REQ-031 The bench SHALL cover RAM: store 0xDEADBEEF to 0x14, then load 0x14 and 0x17 -> rdata=0xDEADBEEF both; load 0x18 unaffected.
REQ-032 The bench SHALL cover synchronizers: sw=0x2A5 from cycle 0 -> read 0x80 =0 at cycles 0-1, =0x2A5 from cycle 2.
REQ-033 The bench SHALL cover EDGE: pulse key[2] high for 3 cycles -> EDGE=0x4 and stays set; write 0x4 to 0x88 -> EDGE=0; key[2] rising on the same edge as the W1C -> EDGE stays 0x4.
REQ-034 The bench SHALL cover the counter: write CTRL=1, wait 10 cycles -> CNT=10; force CNT to 0xFFFFFFFF -> next cycle CNT=0; write CTRL=0x3 -> CNT=0 next cycle, then counting resumes.
REQ-035 The bench SHALL cover outputs and reset: write 0x12345678 to 0xC0 -> out0=0x12345678; assert resetn mid-cycle -> out0=0 immediately; RAM word previously stored is unchanged.
REQ-036 The bench SHALL cover unmapped access: write 0xFFFFFFFF to 0xA0 and to 0x80 -> no register changes, and read 0xA0 returns 0.

Source files
------------

// File: rtl/io_data_mem.sv
// Memory-mapped data RAM plus I/O register block for a simple CPU MEM stage.
// Loads are combinational from addr; stores, synchronizers and counters update on clock.
module io_data_mem #(
   parameter int unsigned RAM_WORDS = 64,
   parameter int unsigned SW_W      = 10,
   parameter int unsigned KEY_W     = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              wmem,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   input  logic [SW_W-1:0]   sw,
   input  logic [KEY_W-1:0]  key,
   output logic [31:0]       out0,
   output logic [31:0]       out1
);

   localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

   localparam logic [5:0] A_SW   = 6'h20;
   localparam logic [5:0] A_KEY  = 6'h21;
   localparam logic [5:0] A_EDGE = 6'h22;
   localparam logic [5:0] A_CNT  = 6'h23;
   localparam logic [5:0] A_CTRL = 6'h24;
   localparam logic [5:0] A_OUT0 = 6'h30;
   localparam logic [5:0] A_OUT1 = 6'h31;

   logic [5:0]        word;
   logic [RAM_AW-1:0] ram_idx;
   logic              wr;
   logic              unused;

   logic [31:0]       ram [RAM_WORDS];

   logic [SW_W-1:0]   sw_meta, sw_sync;
   logic [KEY_W-1:0]  key_meta, key_sync, key_prev;
   logic [KEY_W-1:0]  key_rise, edge_clr, edge_flags;
   logic [31:0]       cnt;
   logic              ctrl_en;
   logic              ctrl_wr;

   assign word    = addr[7:2];
   assign ram_idx = RAM_AW'(addr[6:2]);
   assign wr      = resetn & wmem;
   assign unused  = ^{addr[31:8], addr[1:0]};

   assign key_rise = key_sync & ~key_prev;
   assign edge_clr = (wr && word == A_EDGE) ? wdata[KEY_W-1:0] : '0;
   assign ctrl_wr  = wr && (word == A_CTRL);

   // Only the lower 32 words are reachable; RAM is deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr && !addr[7]) begin
         ram[ram_idx] <= wdata;
      end
   end

   // Two-flop synchronizers, plus one extra key stage for rising-edge detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '0;
         key_sync <= '0;
         key_prev <= '0;
      end else begin
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
         key_meta <= key;
         key_sync <= key_meta;
         key_prev <= key_sync;
      end
   end

   // Set beats a same-cycle write-1-to-clear.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         edge_flags <= '0;
      end else begin
         edge_flags <= (edge_flags & ~edge_clr) | key_rise;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         ctrl_en <= 1'b0;
      end else begin
         if (ctrl_wr && wdata[1]) begin
            cnt <= '0;
         end else if (ctrl_en) begin
            cnt <= cnt + 32'd1;
         end
         if (ctrl_wr) begin
            ctrl_en <= wdata[0];
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out0 <= '0;
         out1 <= '0;
      end else begin
         if (wr && word == A_OUT0) out0 <= wdata;
         if (wr && word == A_OUT1) out1 <= wdata;
      end
   end

   // Side-effect-free combinational load path.
   always_comb begin
      rdata = '0;
      if (!addr[7]) begin
         rdata = ram[ram_idx];
      end else begin
         unique case (word)
            A_SW:    rdata = 32'(sw_sync);
            A_KEY:   rdata = 32'(key_sync);
            A_EDGE:  rdata = 32'(edge_flags);
            A_CNT:   rdata = cnt;
            A_CTRL:  rdata = {31'd0, ctrl_en};
            A_OUT0:  rdata = out0;
            A_OUT1:  rdata = out1;
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_data_mem.sv
// Scoreboard bench for io_data_mem: stimulus pushes model predictions, a negedge monitor compares.
module tb_io_data_mem;

   localparam int unsigned SW_W  = 10;
   localparam int unsigned KEY_W = 4;

   logic              clock  = 1'b0;
   logic              resetn = 1'b0;
   logic              wmem   = 1'b0;
   logic [31:0]       addr   = 32'd0;
   logic [31:0]       wdata  = 32'd0;
   logic [31:0]       rdata;
   logic [SW_W-1:0]   sw     = '0;
   logic [KEY_W-1:0]  key    = '0;
   logic [31:0]       out0, out1;

   always #5 clock = ~clock;

   io_data_mem #(.RAM_WORDS(64), .SW_W(SW_W), .KEY_W(KEY_W)) dut (
      .clock(clock), .resetn(resetn), .wmem(wmem), .addr(addr), .wdata(wdata),
      .rdata(rdata), .sw(sw), .key(key), .out0(out0), .out1(out1)
   );

   typedef struct {
      int          cyc;
      int          kind;   // 0 rdata, 1 out0, 2 out1
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural model of the address map
   logic [31:0]      m_ram [32];
   bit               m_ram_ok [32];
   logic [31:0]      m_out0, m_out1, m_cnt;
   bit               m_ctrl;
   logic [KEY_W-1:0] m_edg;
   logic [SW_W-1:0]  swh [2];    // input samples taken at the last two edges
   logic [KEY_W-1:0] keyh [3];   // input samples taken at the last three edges

   task automatic model_reset();
      m_out0 = 0; m_out1 = 0; m_cnt = 0; m_ctrl = 0; m_edg = '0;
      swh[0] = '0; swh[1] = '0;
      keyh[0] = '0; keyh[1] = '0; keyh[2] = '0;
   endtask

   function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
      v = 32'd0;
      if (!a[7]) begin
         v = m_ram[a[6:2]];
         return m_ram_ok[a[6:2]];
      end
      case (a[7:2])
         6'h20: v = 32'(swh[1]);
         6'h21: v = 32'(keyh[1]);
         6'h22: v = 32'(m_edg);
         6'h23: v = m_cnt;
         6'h24: v = {31'd0, m_ctrl};
         6'h30: v = m_out0;
         6'h31: v = m_out1;
         default: v = 32'd0;
      endcase
      return 1'b1;
   endfunction

   // Applies one rising edge using the inputs that were stable before it.
   task automatic model_edge();
      logic [KEY_W-1:0] rise, clr;
      logic [5:0] sel;
      if (!resetn) begin
         model_reset();
         return;
      end
      sel  = addr[7:2];
      rise = keyh[1] & ~keyh[2];
      clr  = (wmem && sel == 6'h22) ? wdata[KEY_W-1:0] : '0;
      if (wmem && sel == 6'h24) begin
         if (wdata[1]) m_cnt = 0;
         else if (m_ctrl) m_cnt = m_cnt + 1;
         m_ctrl = wdata[0];
      end else if (m_ctrl) begin
         m_cnt = m_cnt + 1;
      end
      m_edg = (m_edg & ~clr) | rise;
      if (wmem && !addr[7]) begin
         m_ram[addr[6:2]] = wdata;
         m_ram_ok[addr[6:2]] = 1'b1;
      end
      if (wmem && sel == 6'h30) m_out0 = wdata;
      if (wmem && sel == 6'h31) m_out1 = wdata;
      swh[1] = swh[0]; swh[0] = sw;
      keyh[2] = keyh[1]; keyh[1] = keyh[0]; keyh[0] = key;
   endtask

   task automatic push_checks(input string nm);
      logic [31:0] v;
      if (model_read(addr, v)) q.push_back('{cyc, 0, v, nm});
      q.push_back('{cyc, 1, m_out0, "out0"});
      q.push_back('{cyc, 2, m_out1, "out1"});
   endtask

   // One cycle: predict this cycle's outputs, then cross the edge.
   task automatic step(input string nm = "rd");
      push_checks(nm);
      @(posedge clock);
      #1;
      model_edge();
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input string nm = "wr");
      wmem = w; addr = a; wdata = d;
      step(nm);
   endtask

   task automatic rd(input logic [31:0] a, input string nm = "rd");
      wmem = 1'b0; addr = a;
      step(nm);
   endtask

   // Monitor: compare every prediction made for the current cycle.
   always @(negedge clock) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = (e.kind == 0) ? rdata : (e.kind == 1) ? out0 : out1;
         vectors++;
         if (act !== e.exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d addr=%h got=%h exp=%h", e.name, e.cyc, addr, act, e.exp);
         end
      end
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 32; i++) m_ram_ok[i] = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;

      // Reset state
      rd(32'h8C, "rst_cnt"); rd(32'h90, "rst_ctrl"); rd(32'h88, "rst_edge"); rd(32'hC4, "rst_out1");

      // Synchronizer latency
      resetn = 1'b1;
      sw = 10'h2A5;
      for (int i = 0; i < 4; i++) rd(32'h80, "sw_sync");

      // Fill RAM so every later load has a known value
      for (int i = 0; i < 32; i++) drive(1'b1, 32'(i * 4), $urandom(), "ram_fill");

      // RAM store/load, byte offset ignored, neighbour unaffected
      drive(1'b1, 32'h14, 32'hDEADBEEF);
      rd(32'h14, "ram_14"); rd(32'h17, "ram_17"); rd(32'h18, "ram_18");
      rd(32'hFFFF_FF14, "ram_hi_bits");

      // EDGE: pulse, W1C, and set-beats-clear
      key = 4'h4;
      for (int i = 0; i < 3; i++) rd(32'h88, "edge_pulse");
      key = 4'h0;
      for (int i = 0; i < 3; i++) rd(32'h88, "edge_hold");
      drive(1'b1, 32'h88, 32'h4, "edge_w1c");
      rd(32'h88, "edge_clr");
      key = 4'h4;
      rd(32'h88, "edge_pre"); rd(32'h88, "edge_pre");
      drive(1'b1, 32'h88, 32'h4, "edge_race");
      rd(32'h88, "edge_setwins");
      key = 4'h0;
      rd(32'h84, "key_rd"); rd(32'h84, "key_rd");
      drive(1'b1, 32'h88, 32'hF, "edge_clrall");
      rd(32'h88, "edge_zero");

      // Counter: run, wrap, clear
      drive(1'b1, 32'h90, 32'h1, "ctrl_on");
      for (int i = 0; i < 11; i++) rd(32'h8C, "cnt_run");
      force dut.cnt = 32'hFFFF_FFFF;
      release dut.cnt;
      m_cnt = 32'hFFFF_FFFF;
      rd(32'h8C, "cnt_max"); rd(32'h8C, "cnt_wrap"); rd(32'h8C, "cnt_after_wrap");
      drive(1'b1, 32'h90, 32'h3, "ctrl_clr");
      for (int i = 0; i < 4; i++) rd(32'h8C, "cnt_resume");
      rd(32'h90, "ctrl_rd");

      // Unmapped and read-only writes are ignored
      drive(1'b1, 32'hA0, 32'hFFFF_FFFF, "wr_unmapped");
      drive(1'b1, 32'h80, 32'hFFFF_FFFF, "wr_ro");
      rd(32'hA0, "rd_unmapped"); rd(32'h80, "sw_after_wr"); rd(32'h84, "key_after_wr");
      rd(32'h88, "edge_after_wr"); rd(32'h90, "ctrl_after_wr");

      // Randomised traffic over RAM, registers and holes
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3: a = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 127));
            4:          a = 32'h80 + 32'($urandom_range(0, 4) * 4);
            5:          a = 32'hC0 + 32'($urandom_range(0, 1) * 4);
            default:    a = ($urandom() & 32'hFFFF_FF00) | 32'h80 | 32'($urandom_range(0, 127));
         endcase
         if ($urandom_range(0, 9) == 0) sw  = SW_W'($urandom());
         if ($urandom_range(0, 4) == 0) key = KEY_W'($urandom());
         drive(1'($urandom_range(0, 1)), a, $urandom(), "random");
      end

      // Output register and asynchronous reset
      key = '0;
      drive(1'b1, 32'hC0, 32'h1234_5678, "out0_wr");
      rd(32'h14, "out0_chk");
      #2 resetn = 1'b0;
      model_reset();
      #1 rd(32'h14, "async_rst");
      drive(1'b1, 32'h14, 32'h0, "wr_in_rst");
      rd(32'h14, "ram_in_rst");
      resetn = 1'b1;
      rd(32'h14, "ram_kept"); rd(32'hC0, "out0_rst");

      repeat (2) @(posedge clock);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain pending=%0d exp=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
